// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and
// pointer width derivation.
package fifo_pkg;

  // Pointers carry one extra wrap bit above the memory address.
  function automatic int ptr_w(input int depth_l);
    return depth_l + 1;
  endfunction

  // Binary to reflected Gray code, computed on a 32-bit container.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary; zero upper bits of a narrower value contribute nothing.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Plain multi-flop synchronizer for a Gray-coded pointer crossing clock
// domains. No logic between stages so only one bit changes per transfer.
module gray_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff [STAGES];

  // Shift the foreign pointer through the synchronizer chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) ff[i] <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray-coded pointer crossings, per-side levels,
// almost flags, error pulses and selectable fall-through output.
module async_fifo_gray
  import fifo_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH_L     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_MARGIN   = 2,
  parameter int AE_MARGIN   = 2,
  parameter bit FWFT        = 1'b1
) (
  input  logic               rclock,
  input  logic               reset,
  input  logic               wclock,
  input  logic               wr,
  input  logic [WIDTH-1:0]   din,
  output logic               full,
  output logic               almost_full,
  output logic [DEPTH_L:0]   wr_level,
  output logic               wr_err,
  input  logic               rd,
  output logic [WIDTH-1:0]   dout,
  output logic               empty,
  output logic               almost_empty,
  output logic [DEPTH_L:0]   rd_level,
  output logic               rd_err
);

  localparam int PW    = ptr_w(DEPTH_L);
  localparam int DEPTH = 1 << DEPTH_L;
  localparam logic [PW-1:0] AF_TH = PW'(DEPTH - AF_MARGIN);
  localparam logic [PW-1:0] AE_TH = PW'(AE_MARGIN);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wbin, wgray, wbin_nx, rgray_s, rbin_s, wr_level_nx;
  logic [PW-1:0] rbin, rgray, rbin_nx, wgray_s, wbin_s, rd_level_nx;
  logic [PW-1:0] full_pat;
  logic          wr_ok, rd_ok;
  logic [WIDTH-1:0] head;

  // Write side: full compares against the read pointer with the two MSBs
  // flipped, i.e. exactly one lap ahead.
  assign full_pat    = {~rgray_s[PW-1:PW-2], rgray_s[PW-3:0]};
  assign full        = (wgray == full_pat);
  assign wr_ok       = wr & ~full;
  assign wbin_nx     = wbin + PW'(wr_ok);
  assign rbin_s      = PW'(gray2bin(32'(rgray_s)));
  assign wr_level_nx = wbin_nx - rbin_s;

  // Write-domain pointer, level, almost-full and overflow pulse.
  always_ff @(posedge wclock or posedge reset) begin
    if (reset) begin
      wbin        <= '0;
      wgray       <= '0;
      wr_level    <= '0;
      almost_full <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      wbin        <= wbin_nx;
      wgray       <= PW'(bin2gray(32'(wbin_nx)));
      wr_level    <= wr_level_nx;
      almost_full <= (wr_level_nx >= AF_TH);
      wr_err      <= wr & full;
    end
  end

  // Storage array, intentionally left without reset.
  always_ff @(posedge wclock) begin
    if (wr_ok) mem[wbin[DEPTH_L-1:0]] <= din;
  end

  // Read side: empty when our Gray pointer matches the synchronised writer.
  assign empty       = (rgray == wgray_s);
  assign rd_ok       = rd & ~empty;
  assign rbin_nx     = rbin + PW'(rd_ok);
  assign wbin_s      = PW'(gray2bin(32'(wgray_s)));
  assign rd_level_nx = wbin_s - rbin_nx;

  // Read-domain pointer, level, almost-empty and underflow pulse.
  always_ff @(posedge rclock or posedge reset) begin
    if (reset) begin
      rbin         <= '0;
      rgray        <= '0;
      rd_level     <= '0;
      almost_empty <= 1'b1;
      rd_err       <= 1'b0;
    end else begin
      rbin         <= rbin_nx;
      rgray        <= PW'(bin2gray(32'(rbin_nx)));
      rd_level     <= rd_level_nx;
      almost_empty <= (rd_level_nx <= AE_TH);
      rd_err       <= rd & empty;
    end
  end

  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wsync (
    .clock (rclock),
    .reset (reset),
    .d     (wgray),
    .q     (wgray_s)
  );

  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rsync (
    .clock (wclock),
    .reset (reset),
    .d     (rgray),
    .q     (rgray_s)
  );

  assign head = mem[rbin[DEPTH_L-1:0]];

  generate
    if (FWFT) begin : g_fwft
      // Fall-through: head word presented whenever data is available.
      assign dout = empty ? '0 : head;
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      // Registered output: load the head word on each accepted read.
      always_ff @(posedge rclock or posedge reset) begin
        if (reset) dout_q <= '0;
        else if (rd_ok) dout_q <= head;
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule
